// File: rtl/ps2_host_tx_pkg.sv
// Shared types and helpers for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT_DEV,
    SEND,
    ACK,
    WAIT_REL,
    DONE,
    ERR
  } tx_state_t;

  // Microseconds to system-clock cycles, truncated to the 24-bit timer width.
  function automatic logic [23:0] US_TO_CYC(input logic [63:0] us, input logic [63:0] clk_hz);
    logic [63:0] cyc;
    cyc = us * clk_hz / 64'd1_000_000;
    return cyc[23:0];
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake and frame status between a client and ps2_host_tx.
// tx_data is taken on a cycle where tx_valid && tx_ready; tx_valid while tx_ready=0 is dropped, not held.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout_err
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Synchronises raw PS/2 clock/data lines; clock gets a 3-sample majority filter and a falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_raw,
  input  logic data_raw,
  output logic clk_filt,
  output logic data_sync,
  output logic fe
);
  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic [2:0] clk_hist;
  logic       maj;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_ff   <= '1;
      data_ff  <= '1;
      clk_hist <= '1;
      clk_filt <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_raw};
      data_ff  <= {data_ff[0], data_raw};
      clk_hist <= {clk_hist[1:0], clk_ff[1]};
      clk_filt <= maj;
    end
  end

  assign maj       = (clk_hist[0] & clk_hist[1]) | (clk_hist[0] & clk_hist[2]) | (clk_hist[1] & clk_hist[2]);
  assign data_sync = data_ff[1];
  assign fe        = clk_filt & ~maj;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one byte, check device ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned START_TO_US = 15000,
  parameter int unsigned FRAME_TO_US = 2000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  output tx_state_t    debug_state
);
  localparam logic [23:0] INHIBIT_CYC = US_TO_CYC(64'(INHIBIT_US), 64'(CLK_HZ));
  localparam logic [23:0] START_CYC   = US_TO_CYC(64'(START_TO_US), 64'(CLK_HZ));
  localparam logic [23:0] FRAME_CYC   = US_TO_CYC(64'(FRAME_TO_US), 64'(CLK_HZ));
  localparam logic [3:0]  LAST_SEND   = 4'(PS2_FRAME_BITS - 3);
  localparam logic [3:0]  ACK_IDX     = 4'(PS2_FRAME_BITS - 1);

  tx_state_t   state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [9:0]  shift_q, shift_d;
  logic        ack_err_q, ack_err_d;
  logic        timeout_err_q, timeout_err_d;
  logic        clk_filt, data_sync, fe;

  ps2_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .clk_raw   (ps2_clk_in),
    .data_raw  (ps2_data_in),
    .clk_filt  (clk_filt),
    .data_sync (data_sync),
    .fe        (fe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '1;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = (cnt_q == '1) ? cnt_q : cnt_q + 24'd1;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    ack_err_d     = ack_err_q;
    timeout_err_d = timeout_err_q;
    ps2_clk_oe    = 1'b0;
    ps2_data_oe   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx.tx_valid) begin
          shift_d       = {1'b1, ~^tx.tx_data, tx.tx_data};
          ack_err_d     = 1'b0;
          timeout_err_d = 1'b0;
          state_d       = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q >= INHIBIT_CYC - 24'd1) state_d = REQ;
      end
      REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT_DEV;
      end
      WAIT_DEV: begin
        ps2_data_oe = 1'b1;
        if (fe) begin
          // Frame timeout runs from the first device edge onwards.
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = SEND;
        end else if (cnt_q >= START_CYC) begin
          timeout_err_d = 1'b1;
          state_d       = ERR;
        end
      end
      SEND: begin
        ps2_data_oe = ~shift_q[0];
        if (cnt_q >= FRAME_CYC) begin
          timeout_err_d = 1'b1;
          state_d       = ERR;
        end else if (fe) begin
          shift_d   = {1'b1, shift_q[9:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == LAST_SEND) state_d = ACK;
        end
      end
      ACK: begin
        if (cnt_q >= FRAME_CYC) begin
          timeout_err_d = 1'b1;
          state_d       = ERR;
        end else if (fe) begin
          ack_err_d = data_sync;
          bit_idx_d = ACK_IDX;
          state_d   = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (cnt_q >= FRAME_CYC) begin
          timeout_err_d = 1'b1;
          state_d       = ERR;
        end else if (clk_filt && data_sync) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tx.tx_ready    = (state_q == IDLE);
  assign tx.busy        = (state_q != IDLE);
  assign tx.done        = (state_q == DONE) || (state_q == ERR);
  assign tx.ack_err     = ack_err_q;
  assign tx.timeout_err = timeout_err_q;
  assign debug_state    = state_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, keyboard BFM, done/frame scoreboards.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int CLK_HZ      = 1_000_000;
  localparam int INHIBIT_CYC = 100;
  localparam int HALF        = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_host_tx_if tx_if ();
  logic      ps2_clk_oe, ps2_data_oe;
  tx_state_t debug_state;
  logic      bfm_clk_low = 1'b0;
  logic      bfm_data_low = 1'b0;
  logic      ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | bfm_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | bfm_data_low);

  ps2_host_tx #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx          (tx_if),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .debug_state (debug_state)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [1:0]  exp_q[$];
  logic [10:0] exp_frame_q[$];
  int bfm_mode = 0;
  logic bfm_busy = 1'b0;
  int first_fall_cyc = 0;
  int inh_run = 0;
  logic [1:0] mon_e;

  logic [7:0] vec_byte[4] = '{8'hED, 8'h00, 8'hFF, 8'h01};
  logic       vec_par[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic range_check(input string name, input int act, input int lo, input int hi);
    total_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // Done monitor: each done pulse pops one expected {ack_err, timeout_err}.
  always @(negedge clk) begin
    if (!reset && tx_if.done) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got done with ack_err=%0b timeout_err=%0b expected none",
                 tx_if.ack_err, tx_if.timeout_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_flags", 32'({tx_if.ack_err, tx_if.timeout_err}), 32'(mon_e));
        check("done_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'(2'b00));
      end
    end
  end

  // Inhibit monitor: every clock-only hold must last exactly the inhibit time.
  always @(negedge clk) begin
    if (!reset && ps2_clk_oe && !ps2_data_oe) inh_run++;
    else if (inh_run != 0) begin
      check("inhibit_len", 32'(inh_run), 32'(INHIBIT_CYC));
      inh_run = 0;
    end
  end

  // Keyboard BFM. Modes: 0 ack low, 1 ack high, 2 never clock, 3 stop after 5 edges, 4 clock without checking.
  task automatic bfm_frame();
    logic [10:0] got;
    logic [10:0] exp_f;
    int m;
    m = bfm_mode;
    got = '0;
    bfm_busy = 1'b1;
    if (m != 2) begin
      repeat (HALF) @(negedge clk);
      got[0] = ps2_data_line;
      for (int i = 1; i <= 10; i++) begin
        if (m != 3 || i <= 5) begin
          bfm_clk_low = 1'b1;
          if (i == 1) first_fall_cyc = cyc;
          repeat (HALF) @(negedge clk);
          bfm_clk_low = 1'b0;
          got[i] = ps2_data_line;
          repeat (HALF) @(negedge clk);
        end
      end
      if (m == 0 || m == 1) begin
        if (exp_frame_q.size() == 0) begin
          total_cnt++;
          $display("FAIL frame: got %03h expected no frame", got);
        end else begin
          exp_f = exp_frame_q.pop_front();
          check("frame", 32'(got), 32'(exp_f));
        end
      end
      if (m != 3) begin
        if (m != 1) bfm_data_low = 1'b1;
        repeat (HALF) @(negedge clk);
        bfm_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        bfm_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        bfm_data_low = 1'b0;
      end
    end
    for (int k = 0; k < 30000 && !ps2_data_line; k++) @(negedge clk);
    bfm_busy = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && ps2_clk_line && !ps2_data_line) bfm_frame();
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!tx_if.tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic wait_state(input tx_state_t s, input int limit);
    int n = 0;
    while (debug_state != s && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", 32'(debug_state), 32'(s));
  endtask

  task automatic wait_done(input int limit, output int at);
    int n = 0;
    while (!tx_if.done && n < limit) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    check("done_seen", 32'(tx_if.done), 32'(1'b1));
    @(negedge clk);
  endtask

  task automatic wait_bfm_idle();
    int n = 0;
    while (bfm_busy && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check("bfm_idle", 32'(bfm_busy), 32'(1'b0));
  endtask

  initial begin
    int t;
    int t0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outs", 32'({tx_if.tx_ready, tx_if.busy, tx_if.done, tx_if.ack_err,
                             tx_if.timeout_err, ps2_clk_oe, ps2_data_oe}), 32'(7'b1000000));

    // Normal frames with hand-computed parity.
    for (int i = 0; i < 4; i++) begin
      bfm_mode = 0;
      exp_frame_q.push_back({1'b1, vec_par[i], vec_byte[i], 1'b0});
      exp_q.push_back(2'b00);
      send(vec_byte[i]);
      if (i == 1) begin
        wait_state(SEND, 2000);
        tx_if.tx_data  = 8'hAA;
        tx_if.tx_valid = 1'b1;
        check("ready_busy_send", 32'({tx_if.tx_ready, tx_if.busy}), 32'(2'b01));
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
      end
      wait_done(3000, t);
      wait_bfm_idle();
    end

    // Device leaves data high on the ACK edge; 0x13 has odd weight so parity 0.
    bfm_mode = 1;
    exp_frame_q.push_back({1'b1, 1'b0, 8'h13, 1'b0});
    exp_q.push_back(2'b10);
    send(8'h13);
    wait_done(3000, t);
    repeat (5) @(negedge clk);
    check("ack_err_hold", 32'({tx_if.ack_err, ps2_clk_oe, ps2_data_oe}), 32'(3'b100));
    wait_bfm_idle();

    // Device never clocks.
    bfm_mode = 2;
    exp_q.push_back(2'b01);
    send(8'hFF);
    check("flags_clear", 32'({tx_if.ack_err, tx_if.timeout_err}), 32'(2'b00));
    wait_state(WAIT_DEV, 500);
    t0 = cyc;
    wait_done(20000, t);
    range_check("start_to_time", t - t0, 15000, 15002);
    wait_bfm_idle();

    // Device stops after five edges.
    bfm_mode = 3;
    exp_q.push_back(2'b01);
    send(8'hAA);
    wait_done(5000, t);
    range_check("frame_to_time", t - first_fall_cyc, 2000, 2010);
    check("timeout_hold", 32'({tx_if.timeout_err, ps2_clk_oe, ps2_data_oe}), 32'(3'b100));
    wait_bfm_idle();

    // Reset in the middle of a frame, then a clean send.
    bfm_mode = 4;
    send(8'h55);
    wait_state(SEND, 2000);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid", 32'({ps2_clk_oe, ps2_data_oe, tx_if.busy, tx_if.tx_ready}), 32'(4'b0001));
    reset = 1'b0;
    wait_bfm_idle();

    bfm_mode = 0;
    exp_frame_q.push_back({1'b1, 1'b1, 8'h5A, 1'b0});
    exp_q.push_back(2'b00);
    send(8'h5A);
    wait_done(3000, t);
    wait_bfm_idle();

    repeat (10) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("frame_q_drained", 32'(exp_frame_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
